// File: rtl/pipeline_stall_controller_if.sv
// Handshake bundle between the ID-stage hazard logic/data memory and the
// pipeline stall controller. The controller uses the slave view.
interface pipeline_stall_controller_if #(
    parameter int CNT_W = 32
);
    logic             hazard_detected;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             perf_clr;
    logic             pc_write_en;
    logic             ifid_write_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_freeze;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output hazard_detected, branch_taken, dmem_req, dmem_ready, perf_clr,
        input  pc_write_en, ifid_write_en, ifid_flush, idex_bubble,
               pipe_freeze, mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  hazard_detected, branch_taken, dmem_req, dmem_ready, perf_clr,
        output pc_write_en, ifid_write_en, ifid_flush, idex_bubble,
               pipe_freeze, mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Turns load-use / branch / data-memory-wait conditions into stall, flush and
// freeze controls. Define STALL_PERF_CNT_EN to build the stall/flush counters.
module pipeline_stall_controller #(
    parameter int LOAD_USE_CYC = 1,
    parameter int TIMEOUT_CYC  = 256,
    parameter int CNT_W        = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    pipeline_stall_controller_if.slave        ctl
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    localparam int WAIT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYC);
    localparam logic [1:0] LU_INIT =
        (LOAD_USE_CYC > 1) ? 2'(LOAD_USE_CYC - 2) : 2'd0;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_lu_cnt;
    logic [1:0]          w_lu_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_mem_timeout;

    logic                w_mem_wait;
    logic                w_frozen;
    logic                w_to_hit;
    logic                w_pc_we;
    logic                w_ifid_we;
    logic                w_flush;
    logic                w_bubble;
    logic                w_freeze;

    assign w_mem_wait = ctl.dmem_req & ~ctl.dmem_ready;
    assign w_frozen   = w_mem_wait | (r_state == TIMEOUT);
    assign w_to_hit   = (TIMEOUT_CYC > 0) && w_mem_wait && (r_wait_cnt == WAIT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_lu_nxt    = r_lu_cnt;
        w_pc_we     = 1'b1;
        w_ifid_we   = 1'b1;
        w_flush     = 1'b0;
        w_bubble    = 1'b0;
        w_freeze    = 1'b0;

        // A freeze holds everything upstream, so branch/hazard are re-presented later.
        if (w_frozen) begin
            w_freeze  = 1'b1;
            w_pc_we   = 1'b0;
            w_ifid_we = 1'b0;
        end else if (ctl.branch_taken) begin
            w_flush     = 1'b1;
            w_bubble    = 1'b1;
            w_state_nxt = RUN;
            w_lu_nxt    = 2'd0;
        end else if (r_state == LU_STALL) begin
            w_pc_we   = 1'b0;
            w_ifid_we = 1'b0;
            w_bubble  = 1'b1;
            if (r_lu_cnt == 2'd0) begin
                w_state_nxt = RUN;
            end else begin
                w_lu_nxt = r_lu_cnt - 2'd1;
            end
        end else if (ctl.hazard_detected) begin
            w_pc_we   = 1'b0;
            w_ifid_we = 1'b0;
            w_bubble  = 1'b1;
            if (LOAD_USE_CYC > 1) begin
                w_state_nxt = LU_STALL;
                w_lu_nxt    = LU_INIT;
            end
        end

        if (w_to_hit) begin
            w_state_nxt = TIMEOUT;
        end

        // Inputs may be garbage while reset is held; present a clean run state.
        if (!rst_n) begin
            w_pc_we   = 1'b1;
            w_ifid_we = 1'b1;
            w_flush   = 1'b0;
            w_bubble  = 1'b0;
            w_freeze  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_lu_cnt      <= 2'd0;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_lu_cnt <= w_lu_nxt;
            if (w_mem_wait) begin
                if (r_wait_cnt != WAIT_MAX) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_to_hit) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    assign ctl.pc_write_en   = w_pc_we;
    assign ctl.ifid_write_en = w_ifid_we;
    assign ctl.ifid_flush    = w_flush;
    assign ctl.idex_bubble   = w_bubble;
    assign ctl.pipe_freeze   = w_freeze;
    assign ctl.mem_timeout   = r_mem_timeout;

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Clear wins over increment; both counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (ctl.perf_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_we && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign ctl.stall_cnt = r_stall_cnt;
    assign ctl.flush_cnt = r_flush_cnt;
`else
    logic w_unused_perf_clr;
    assign w_unused_perf_clr = ctl.perf_clr;
    assign ctl.stall_cnt     = '0;
    assign ctl.flush_cnt     = '0;
`endif
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Drives three differently-parameterised controllers from shared stimulus and
// checks them against directed expectations and a bubble-count reference model.
module tb_pipeline_stall_controller;
    logic clk = 1'b0;
    logic rst_n;
    logic hz, br, req, rdy, pclr;

    always #5 clk = ~clk;

    pipeline_stall_controller_if #(.CNT_W(4))  if0();
    pipeline_stall_controller_if #(.CNT_W(32)) if1();
    pipeline_stall_controller_if #(.CNT_W(8))  if2();

    assign if0.hazard_detected = hz;  assign if0.branch_taken = br;
    assign if0.dmem_req = req;        assign if0.dmem_ready = rdy;  assign if0.perf_clr = pclr;
    assign if1.hazard_detected = hz;  assign if1.branch_taken = br;
    assign if1.dmem_req = req;        assign if1.dmem_ready = rdy;  assign if1.perf_clr = pclr;
    assign if2.hazard_detected = hz;  assign if2.branch_taken = br;
    assign if2.dmem_req = req;        assign if2.dmem_ready = rdy;  assign if2.perf_clr = pclr;

    pipeline_stall_controller #(.LOAD_USE_CYC(1), .TIMEOUT_CYC(4), .CNT_W(4))
        u0 (.clk(clk), .rst_n(rst_n), .ctl(if0.slave));
    pipeline_stall_controller #(.LOAD_USE_CYC(2), .TIMEOUT_CYC(256), .CNT_W(32))
        u1 (.clk(clk), .rst_n(rst_n), .ctl(if1.slave));
    pipeline_stall_controller #(.LOAD_USE_CYC(3), .TIMEOUT_CYC(0), .CNT_W(8))
        u2 (.clk(clk), .rst_n(rst_n), .ctl(if2.slave));

    int checks = 0;
    int errors = 0;

    // {pc_we, ifid_we, flush, bubble, freeze, timeout}
    localparam logic [5:0] O_RUN    = 6'b110000;
    localparam logic [5:0] O_STALL  = 6'b000100;
    localparam logic [5:0] O_FLUSH  = 6'b111100;
    localparam logic [5:0] O_FREEZE = 6'b000010;
    localparam logic [5:0] O_TOUT   = 6'b000011;

    function automatic logic [5:0] obs(int k);
        case (k)
            0: return {if0.pc_write_en, if0.ifid_write_en, if0.ifid_flush,
                       if0.idex_bubble, if0.pipe_freeze, if0.mem_timeout};
            1: return {if1.pc_write_en, if1.ifid_write_en, if1.ifid_flush,
                       if1.idex_bubble, if1.pipe_freeze, if1.mem_timeout};
            default: return {if2.pc_write_en, if2.ifid_write_en, if2.ifid_flush,
                             if2.idex_bubble, if2.pipe_freeze, if2.mem_timeout};
        endcase
    endfunction

    function automatic logic [31:0] scnt(int k);
        case (k)
            0: return 32'(if0.stall_cnt);
            1: return if1.stall_cnt;
            default: return 32'(if2.stall_cnt);
        endcase
    endfunction

    function automatic logic [31:0] fcnt(int k);
        case (k)
            0: return 32'(if0.flush_cnt);
            1: return if1.flush_cnt;
            default: return 32'(if2.flush_cnt);
        endcase
    endfunction

    function automatic logic [31:0] perf_exp(longint v);
`ifdef STALL_PERF_CNT_EN
        return 32'(v);
`else
        return (v == v) ? 32'd0 : 32'd1;
`endif
    endfunction

    task automatic drive(logic h, logic b, logic rq, logic rd, logic pc);
        hz = h; br = b; req = rq; rdy = rd; pclr = pc;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(1, 1, 1, 0, 1);
        #2;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs(k) !== O_RUN) begin
                errors++; $display("FAIL reset_out dut%0d got %b exp %b", k, obs(k), O_RUN);
            end
            checks++;
            if (scnt(k) !== 32'd0 || fcnt(k) !== 32'd0) begin
                errors++; $display("FAIL reset_cnt dut%0d got %0d/%0d exp 0/0", k, scnt(k), fcnt(k));
            end
        end
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    task automatic test_lu_single();
        logic [5:0] e0 [3] = '{O_STALL, O_RUN, O_RUN};
        logic [5:0] e2 [3] = '{O_STALL, O_STALL, O_STALL};
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            drive(c == 0, 0, 0, 0, 0);
            #2;
            checks++;
            if (obs(0) !== e0[c]) begin
                errors++; $display("FAIL lu1_seq c%0d got %b exp %b", c, obs(0), e0[c]);
            end
            checks++;
            if (obs(2) !== e2[c]) begin
                errors++; $display("FAIL lu3_seq c%0d got %b exp %b", c, obs(2), e2[c]);
            end
            next_cycle();
        end
        drive(0, 0, 0, 0, 0); #2;
        checks++;
        if (obs(2) !== O_RUN) begin
            errors++; $display("FAIL lu3_done got %b exp %b", obs(2), O_RUN);
        end
    endtask

    task automatic test_branch_cancel();
        logic [5:0] e [4] = '{O_STALL, O_FLUSH, O_RUN, O_RUN};
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            drive(c == 0, c == 1, 0, 0, 0);
            #2;
            checks++;
            if (obs(2) !== e[c]) begin
                errors++; $display("FAIL branch_cancel c%0d got %b exp %b", c, obs(2), e[c]);
            end
            next_cycle();
        end
    endtask

    task automatic test_freeze_in_stall();
        logic [5:0] e;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            if (c == 0)      begin drive(1, 0, 0, 0, 0); e = O_STALL;  end
            else if (c < 6)  begin drive(0, 0, 1, 0, 0); e = O_FREEZE; end
            else if (c == 6) begin drive(0, 0, 1, 1, 0); e = O_STALL;  end
            else             begin drive(0, 0, 0, 0, 0); e = O_RUN;    end
            #2;
            checks++;
            if (obs(1) !== e) begin
                errors++; $display("FAIL freeze_stall c%0d got %b exp %b", c, obs(1), e);
            end
            next_cycle();
        end
        checks++;
        if (scnt(1) !== perf_exp(7)) begin
            errors++; $display("FAIL freeze_stall_cnt got %0d exp %0d", scnt(1), perf_exp(7));
        end
    endtask

    task automatic test_hazard_branch_same();
        apply_reset();
        drive(1, 1, 0, 0, 0); #2;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs(k) !== O_FLUSH) begin
                errors++; $display("FAIL hz_br dut%0d got %b exp %b", k, obs(k), O_FLUSH);
            end
        end
        next_cycle();
        drive(0, 0, 0, 0, 0); #2;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs(k) !== O_RUN) begin
                errors++; $display("FAIL hz_br_after dut%0d got %b exp %b", k, obs(k), O_RUN);
            end
        end
    endtask

    task automatic test_timeout();
        logic [5:0] e;
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            if (c < 4)       begin drive(0, 0, 1, 0, 0); e = O_FREEZE; end
            else if (c == 4) begin drive(1, 1, 1, 1, 0); e = O_TOUT;   end
            else             begin drive(0, 0, 0, 0, 0); e = O_TOUT;   end
            #2;
            checks++;
            if (obs(0) !== e) begin
                errors++; $display("FAIL timeout c%0d got %b exp %b", c, obs(0), e);
            end
            next_cycle();
        end
        checks++;
        if (obs(1) !== O_RUN) begin
            errors++; $display("FAIL timeout_long got %b exp %b", obs(1), O_RUN);
        end
        rst_n = 1'b0; #1;
        checks++;
        if (obs(0) !== O_RUN) begin
            errors++; $display("FAIL timeout_reset got %b exp %b", obs(0), O_RUN);
        end
        rst_n = 1'b1; #1;
        checks++;
        if (obs(0) !== O_RUN) begin
            errors++; $display("FAIL timeout_post_reset got %b exp %b", obs(0), O_RUN);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int c = 0; c < 20; c++) begin drive(1, 0, 0, 0, 0); next_cycle(); end
        for (int c = 0; c < 3; c++)  begin drive(0, 1, 0, 0, 0); next_cycle(); end
        drive(0, 0, 0, 0, 0); #2;
        checks++;
        if (scnt(0) !== perf_exp(15) || fcnt(0) !== perf_exp(3)) begin
            errors++; $display("FAIL sat_cnt4 got %0d/%0d exp %0d/%0d",
                               scnt(0), fcnt(0), perf_exp(15), perf_exp(3));
        end
        checks++;
        if (scnt(1) !== perf_exp(20) || fcnt(1) !== perf_exp(3)) begin
            errors++; $display("FAIL sat_cnt32 got %0d/%0d exp %0d/%0d",
                               scnt(1), fcnt(1), perf_exp(20), perf_exp(3));
        end
        drive(1, 0, 0, 0, 1); next_cycle();
        drive(0, 0, 0, 0, 0); #2;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (scnt(k) !== 32'd0 || fcnt(k) !== 32'd0) begin
                errors++; $display("FAIL perf_clr dut%0d got %0d/%0d exp 0/0", k, scnt(k), fcnt(k));
            end
        end
    endtask

    // Reference model: remaining bubbles, consecutive wait count, sticky timeout.
    task automatic test_random();
        int     lu [3] = '{1, 2, 3};
        int     to [3] = '{4, 256, 0};
        int     cw [3] = '{4, 32, 8};
        int     rem [3], waits [3];
        bit     tout [3];
        longint sc [3], fc [3];
        logic [5:0] e;
        bit     mw, fr;
        int     errs_before;
        apply_reset();
        for (int k = 0; k < 3; k++) begin rem[k] = 0; waits[k] = 0; tout[k] = 0; sc[k] = 0; fc[k] = 0; end
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 29) == 0);
            #2;
            mw = req & ~rdy;
            for (int k = 0; k < 3; k++) begin
                if (!rst_n) begin rem[k] = 0; waits[k] = 0; tout[k] = 0; sc[k] = 0; fc[k] = 0; end
                fr = mw | tout[k];
                if (!rst_n)                    e = O_RUN;
                else if (fr)                   e = {5'b00001, tout[k]};
                else if (br)                   e = {5'b11110, tout[k]};
                else if (rem[k] > 0 || hz)     e = {5'b00010, tout[k]};
                else                           e = {5'b11000, tout[k]};
                errs_before = errors;
                checks++;
                if (obs(k) !== e) begin
                    errors++; $display("FAIL rand_out c%0d dut%0d got %b exp %b", c, k, obs(k), e);
                end
                checks++;
                if (scnt(k) !== perf_exp(sc[k]) || fcnt(k) !== perf_exp(fc[k])) begin
                    errors++; $display("FAIL rand_cnt c%0d dut%0d got %0d/%0d exp %0d/%0d",
                                       c, k, scnt(k), fcnt(k), perf_exp(sc[k]), perf_exp(fc[k]));
                end
                if (errors - errs_before > 0 && errors > 20) begin
                    $display("CHECKS %0d ERRORS %0d", checks, errors);
                    $finish;
                end
                if (rst_n) begin
                    if (pclr) begin
                        sc[k] = 0; fc[k] = 0;
                    end else begin
                        if (!e[5] && sc[k] < (longint'(1) << cw[k]) - 1) sc[k]++;
                        if (e[3]  && fc[k] < (longint'(1) << cw[k]) - 1) fc[k]++;
                    end
                    if (!fr) begin
                        if (br)              rem[k] = 0;
                        else if (rem[k] > 0) rem[k]--;
                        else if (hz)         rem[k] = lu[k] - 1;
                    end
                    waits[k] = mw ? waits[k] + 1 : 0;
                    if (to[k] > 0 && mw && waits[k] == to[k]) tout[k] = 1;
                end
            end
            next_cycle();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        test_reset();
        test_lu_single();
        test_branch_cancel();
        test_freeze_in_stall();
        test_hazard_branch_same();
        test_timeout();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Pipeline control sequencer that consumes the load-use hazard flag, branch-taken flag and data-memory handshake, and drives PC/IF-ID write enables, IF/ID flush, ID/EX bubble insertion and global pipeline freeze. It sits in the ID stage beside the hazard detection unit and turns its single-cycle combinational detection into timed stall, flush and freeze sequences. It also provides a data-memory wait timeout and optional stall/flush performance counters.

## Interface
- LOAD_USE_CYC, 1, bubble cycles inserted per load-use hazard; legal 1..3
- TIMEOUT_CYC, 256, consecutive memory-wait cycles before timeout; 0 disables timeout
- CNT_W, 32, performance counter width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- hazard_detected  in  1  load-use hazard from the ID-stage hazard detection unit
- branch_taken  in  1  branch resolved taken; younger IF/ID and ID/EX contents are squashed
- dmem_req  in  1  MEM stage has an outstanding load/store request
- dmem_ready  in  1  data memory completes the request this cycle
- perf_clr  in  1  synchronous clear of the performance counters
- pc_write_en  out  1  PC register load enable
- ifid_write_en  out  1  IF/ID register load enable
- ifid_flush  out  1  IF/ID loads a NOP
- idex_bubble  out  1  ID/EX control fields forced to zero
- pipe_freeze  out  1  EX/MEM and MEM/WB hold; ID/EX holds unless idex_bubble
- mem_timeout  out  1  sticky error: memory wait exceeded TIMEOUT_CYC
- stall_cnt  out  CNT_W  cycles with pc_write_en=0
- flush_cnt  out  CNT_W  cycles with ifid_flush=1

## Operation
- States: RUN, LU_STALL, TIMEOUT. Registers: state, lu_cnt (2 b), wait_cnt ($clog2(TIMEOUT_CYC+1) b), mem_timeout.
- mem_wait = dmem_req & ~dmem_ready. frozen = mem_wait | (state==TIMEOUT).
- Output priority, combinational from state and inputs:
  - frozen: pipe_freeze=1, pc_write_en=0, ifid_write_en=0, ifid_flush=0, idex_bubble=0. State and lu_cnt hold.
  - else branch_taken: pc_write_en=1, ifid_write_en=1, ifid_flush=1, idex_bubble=1. Next state RUN; a pending LU_STALL is cancelled.
  - else state==LU_STALL, or RUN & hazard_detected: pc_write_en=0, ifid_write_en=0, idex_bubble=1.
  - else: pc_write_en=1, ifid_write_en=1, all others 0.
- RUN→LU_STALL on an unfrozen hazard_detected with no branch_taken, when LOAD_USE_CYC>1; lu_cnt loads LOAD_USE_CYC-2. LU_STALL decrements lu_cnt on each unfrozen cycle and returns to RUN when lu_cnt==0. Total bubbles = LOAD_USE_CYC.
- hazard_detected is ignored while in LU_STALL.
- wait_cnt increments on each mem_wait cycle and clears on any cycle without mem_wait.
- With TIMEOUT_CYC>0: mem_wait while wait_cnt==TIMEOUT_CYC-1 moves the next state to TIMEOUT and sets mem_timeout. TIMEOUT is terminal until reset.
- While frozen, branch_taken and hazard_detected are not acted on. The upstream registers hold, so these inputs are re-presented after the freeze.

## Timing
- Reset (async): state=RUN, lu_cnt=0, wait_cnt=0, mem_timeout=0, counters=0.
- Outputs with rst_n low: pc_write_en=1, ifid_write_en=1, all other outputs 0.
- Stall, flush and freeze respond in the same cycle as their inputs (zero latency). Sequencing effects appear from the next edge.
- dmem_ready is accepted in any cycle; the freeze drops in that same cycle.
- Reset asserted mid-stall or mid-timeout returns to RUN immediately.

## Configuration
- STALL_PERF_CNT_EN defined:
  - stall_cnt increments on each cycle with pc_write_en=0; flush_cnt increments on each cycle with ifid_flush=1.
  - Both saturate at all-ones.
  - perf_clr zeroes both and takes priority over increment.
- STALL_PERF_CNT_EN undefined: stall_cnt and flush_cnt are tied to 0, perf_clr is ignored, and no counter flops exist.

## Test plan
- LOAD_USE_CYC=1, hazard_detected pulse 1 cycle → pc_write_en=0, ifid_write_en=0, idex_bubble=1 for exactly 1 cycle, then normal.
- LOAD_USE_CYC=3, hazard pulse, branch_taken on the 2nd stall cycle → 1 stall cycle, then flush cycle (ifid_flush=1, idex_bubble=1, pc_write_en=1), then RUN with no further stall.
- dmem_req=1, dmem_ready low for 5 cycles during LU_STALL with LOAD_USE_CYC=2 → pipe_freeze=1 for 5 cycles, the remaining bubble is issued after dmem_ready, and stall_cnt advances by 5 freeze cycles plus 2 bubble cycles.
- Simultaneous hazard_detected and branch_taken in RUN → flush outputs only, state stays RUN.
- TIMEOUT_CYC=4, dmem_ready held low → mem_timeout rises after the 4th wait cycle, freeze persists after dmem_ready=1, and rst_n low clears everything.
- With STALL_PERF_CNT_EN, CNT_W=4, 20 stall cycles → stall_cnt=15 (saturated); perf_clr for 1 cycle → 0.
